// File: rtl/rr_grant_encoder8.sv
// Eight-requester round-robin arbiter with a binary-encoded grant for the 3-to-8 decoder.
// Grants are held until done, request drop or timeout, with one dead cycle between owners.
//
//   state | meaning
//   IDLE  | no grant active, arbitrating every cycle
//   BUSY  | grant held by grant_idx, busy_cycles counting
//   GAP   | single dead cycle after a release, arbitrating for the next owner
module rr_grant_encoder8 #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic       grant_valid,
    output logic [2:0] grant_idx,
    output logic       timeout_err,
    output logic [7:0] busy_cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic       TIMEOUT_EN  = (TIMEOUT != 0);

    state_t     state_q;
    logic [2:0] ptr_q;
    logic       grant_valid_q;
    logic [2:0] grant_idx_q;
    logic       timeout_err_q;
    logic [7:0] busy_cycles_q;

    logic       win_found;
    logic [2:0] win_idx;
    logic [2:0] cand;
    logic       owner_req;
    logic       timed_out;
    logic       release_now;

    // Rotating priority search starting at ptr_q and wrapping modulo 8.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = '0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign owner_req   = req[grant_idx_q];
    assign timed_out   = TIMEOUT_EN && (busy_cycles_q == TIMEOUT_CNT);
    assign release_now = done || !owner_req || timed_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            timeout_err_q <= 1'b0;
            busy_cycles_q <= '0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE, GAP: begin
                    if (win_found) begin
                        state_q       <= BUSY;
                        grant_valid_q <= 1'b1;
                        grant_idx_q   <= win_idx;
                        busy_cycles_q <= 8'd1;
                    end else begin
                        state_q       <= IDLE;
                        grant_valid_q <= 1'b0;
                        busy_cycles_q <= '0;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        state_q       <= GAP;
                        grant_valid_q <= 1'b0;
                        busy_cycles_q <= '0;
                        ptr_q         <= grant_idx_q + 3'd1;
                        // A normal release wins over a coincident timeout.
                        timeout_err_q <= timed_out && !done && owner_req;
                    end else if (busy_cycles_q != 8'hFF) begin
                        busy_cycles_q <= busy_cycles_q + 8'd1;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    grant_valid_q <= 1'b0;
                    busy_cycles_q <= '0;
                end
            endcase
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;
    assign timeout_err = timeout_err_q;
    assign busy_cycles = busy_cycles_q;

endmodule

// File: tb/tb_rr_grant_encoder8.sv
// Directed bench for rr_grant_encoder8 with hand-computed expectations (TIMEOUT=4).
module tb_rr_grant_encoder8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic       timeout_err;
    logic [7:0] busy_cycles;

    int n_cmp;
    int n_bad;

    rr_grant_encoder8 #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .timeout_err (timeout_err),
        .busy_cycles (busy_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int gv, input int idx,
                              input int terr, input int busy);
        chk({tag, ".gv"},   int'(grant_valid), gv);
        chk({tag, ".idx"},  int'(grant_idx),   idx);
        chk({tag, ".terr"}, int'(timeout_err), terr);
        chk({tag, ".busy"}, int'(busy_cycles), busy);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b1;
        req   = 8'h00;
        done  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        expect_out("reset", 0, 0, 0, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        expect_out("idle", 0, 0, 0, 0);

        // Test 1: single requester 2, done after three busy cycles
        req = 8'b0000_0100;
        step();
        expect_out("t1.grant", 1, 2, 0, 1);
        step();
        chk("t1.busy2", int'(busy_cycles), 2);
        step();
        chk("t1.busy3", int'(busy_cycles), 3);
        done = 1'b1;
        step();
        expect_out("t1.gap", 0, 2, 0, 0);
        done = 1'b0;
        req  = 8'b0000_1100;
        step();
        expect_out("t1.ptr3", 1, 3, 0, 1);
        done = 1'b1;
        step();
        chk("t1.rel.gv", int'(grant_valid), 0);
        done = 1'b0;
        req  = 8'h00;
        step();
        chk("t1.idle.gv", int'(grant_valid), 0);

        // Test 2: all requesting, done held, full rotation from ptr=0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req  = 8'hFF;
        done = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            chk($sformatf("t2.gv%0d", k), int'(grant_valid), 1);
            chk($sformatf("t2.idx%0d", k), int'(grant_idx), k % 8);
            step();
            chk($sformatf("t2.gap%0d", k), int'(grant_valid), 0);
        end
        req  = 8'h00;
        done = 1'b0;
        step();

        // Test 3: ptr=6 after grant to 5, then wrap to 0
        req = 8'b0010_0000;
        step();
        chk("t3.idx5", int'(grant_idx), 5);
        done = 1'b1;
        step();
        chk("t3.gap1", int'(grant_valid), 0);
        done = 1'b0;
        req  = 8'b0100_0001;
        step();
        expect_out("t3.idx6", 1, 6, 0, 1);
        done = 1'b1;
        step();
        chk("t3.gap2", int'(grant_valid), 0);
        done = 1'b0;
        step();
        expect_out("t3.wrap0", 1, 0, 0, 1);
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 8'h00;
        step();

        // Test 4: timeout at busy_cycles==4, then done coinciding with timeout
        req = 8'b0000_1000;
        for (int b = 1; b <= 4; b++) begin
            step();
            expect_out($sformatf("t4.busy%0d", b), 1, 3, 0, b);
        end
        step();
        expect_out("t4.tmo", 0, 3, 1, 0);
        step();
        expect_out("t4.regrant", 1, 3, 0, 1);
        step();
        step();
        step();
        chk("t4.busy4b", int'(busy_cycles), 4);
        done = 1'b1;
        step();
        expect_out("t4.done_tmo", 0, 3, 0, 0);
        done = 1'b0;

        // Test 5: owner 3 drops its request while 5 waits
        step();
        chk("t5.idx3", int'(grant_idx), 3);
        req = 8'b0010_0000;
        step();
        expect_out("t5.drop", 0, 3, 0, 0);
        step();
        expect_out("t5.idx5", 1, 5, 0, 1);

        // Test 6: reset mid-grant of 4, then ptr=0 priority picks 4 over 7
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 8'b0001_0000;
        step();
        expect_out("t6.idx4", 1, 4, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        expect_out("t6.async", 0, 0, 0, 0);
        req = 8'b1001_0000;
        step();
        rst_n = 1'b1;
        step();
        expect_out("t6.after", 1, 4, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
